// File: rtl/fortaegis_pkg.sv
// fortaegis_pkg
//   Shared definitions for the capture-memory dump reader.
//   - state_t        : dump sequencer states
//   - DATA_W_DEF     : default sample word width
//   - ADDR_W_DEF     : default capture memory address width
//   - HDR_COUNT_LSB  : bit position of the saturated count inside the header word
//                      (header = count zero-extended, used only with DUMP_HEADER_EN)
package fortaegis_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 10;
    localparam int HDR_COUNT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fortaegis_skid_buf.sv
// fortaegis_skid_buf
//   Two-entry valid/ready buffer that absorbs the capture memory read latency.
//   The writer only pushes when it has reserved room, so there is no in_ready.
//   Ports:
//     clk200, rstn          clock, async active-low reset
//     in_valid/in_data/in_last   word returning from memory
//     out_valid/out_ready/out_data/out_last   downstream stream (registered head)
//     occupancy             number of words held (0..2)
module fortaegis_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk200,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        occupancy
);

    logic [DATA_W:0] ent0, ent1;
    logic [1:0]      occ;
    logic            pop;

    assign pop       = (occ != 2'd0) && out_ready;
    assign out_valid = (occ != 2'd0);
    assign out_data  = ent0[DATA_W-1:0];
    assign out_last  = ent0[DATA_W];
    assign occupancy = occ;

    // ent0 is always the head, so the output holds steady while stalled.
    always_ff @(posedge clk200 or negedge rstn) begin
        if (!rstn) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= 2'd0;
        end else begin
            case ({in_valid, pop})
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                2'b10: begin
                    if (occ == 2'd0) ent0 <= {in_last, in_data};
                    else             ent1 <= {in_last, in_data};
                    occ <= occ + 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        ent0 <= {in_last, in_data};
                    end else begin
                        ent0 <= ent1;
                        ent1 <= {in_last, in_data};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fortaegis_dump_reader.sv
// fortaegis_dump_reader
//   Walks the capture memory from address 0 to count-1 after Collect falls and
//   streams the words out on a valid/ready interface in the clk200 domain.
//   Optional feature macro: DUMP_HEADER_EN (prepends a header word holding the
//   saturated count; data and done_o shift by one).
//   Ports:
//     clk200, rstn                         clock, async active-low reset
//     collect_i                            Collect level, asynchronous
//     wr_count_i                           words written (stable while Collect low)
//     mem_rd_en_o/mem_rd_addr_o/mem_rd_data_i   memory read port, 1-cycle latency
//     m_valid_o/m_ready_i/m_data_o/m_last_o     output stream
//     busy_o, done_o                       status
//
//   state | meaning
//   IDLE  | waiting for a synced Collect falling edge
//   READ  | issuing reads, at most two words buffered or in flight
//   DRAIN | all reads issued, waiting for the last word to be accepted
//   DONE  | one-cycle done_o pulse
module fortaegis_dump_reader
    import fortaegis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk200,
    input  logic              rstn,
    input  logic              collect_i,
    input  logic [ADDR_W:0]   wr_count_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic              sync_1, sync_2, sync_prev;
    logic [ADDR_W:0]   cnt, idx, cnt_sat;
    logic              rd_pending, rd_last;
    logic              trigger, pop, can_issue, issue_last;
    logic [1:0]        occ, room_used;
    logic [DATA_W-1:0] push_data;
    logic              hdr_pending, hdr_en;

`ifdef DUMP_HEADER_EN
    logic rd_is_hdr;

    assign hdr_en = 1'b1;

    // The header travels the same one-cycle "read" path as memory data so it
    // shares the buffer accounting and simply occupies the first issue slot.
    always_ff @(posedge clk200 or negedge rstn) begin
        if (!rstn) begin
            hdr_pending <= 1'b0;
            rd_is_hdr   <= 1'b0;
        end else begin
            rd_is_hdr <= can_issue && hdr_pending;
            if (trigger)        hdr_pending <= 1'b1;
            else if (can_issue) hdr_pending <= 1'b0;
        end
    end

    assign push_data = rd_is_hdr ? (DATA_W'(cnt) << HDR_COUNT_LSB) : mem_rd_data_i;
`else
    assign hdr_en      = 1'b0;
    assign hdr_pending = 1'b0;
    assign push_data   = mem_rd_data_i;
`endif

    assign trigger   = (state == IDLE) && sync_prev && !sync_2;
    assign cnt_sat   = (wr_count_i > FULL_CNT) ? FULL_CNT : wr_count_i;
    assign pop       = m_valid_o && m_ready_i;
    // Count a word leaving this cycle as already gone so a continuously ready
    // sink sees one word per cycle.
    assign room_used = occ - {1'b0, pop} + {1'b0, rd_pending};
    assign can_issue = (state == READ) && (room_used < 2'd2);
    assign issue_last = hdr_pending ? (cnt == '0) : (idx == cnt - ONE_CNT);

    assign mem_rd_en_o   = can_issue && !hdr_pending;
    assign mem_rd_addr_o = mem_rd_en_o ? idx[ADDR_W-1:0] : '0;

    always_ff @(posedge clk200 or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            sync_prev  <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            rd_pending <= 1'b0;
            rd_last    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            sync_1     <= collect_i;
            sync_2     <= sync_1;
            sync_prev  <= sync_2;
            rd_pending <= can_issue;
            rd_last    <= can_issue && issue_last;
            done_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        cnt <= cnt_sat;
                        idx <= '0;
                        if ((cnt_sat == '0) && !hdr_en) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state  <= READ;
                            busy_o <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (can_issue) begin
                        if (!hdr_pending) idx <= idx + ONE_CNT;
                        if (issue_last)   state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && m_last_o) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fortaegis_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk200    (clk200),
        .rstn      (rstn),
        .in_valid  (rd_pending),
        .in_data   (push_data),
        .in_last   (rd_last),
        .out_valid (m_valid_o),
        .out_ready (m_ready_i),
        .out_data  (m_data_o),
        .out_last  (m_last_o),
        .occupancy (occ)
    );

endmodule

// File: tb/tb_fortaegis_dump_reader.sv
module tb_fortaegis_dump_reader;

    localparam int DW = 32;
    localparam int AW = 10;
`ifdef DUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic          clk200 = 1'b0;
    logic          rstn = 1'b0;
    logic          collect_i = 1'b0;
    logic [AW:0]   wr_count_i = '0;
    logic          mem_rd_en_o;
    logic [AW-1:0] mem_rd_addr_o;
    logic [DW-1:0] mem_rd_data_i = '0;
    logic          m_valid_o;
    logic          m_ready_i = 1'b1;
    logic [DW-1:0] m_data_o;
    logic          m_last_o;
    logic          busy_o;
    logic          done_o;

    fortaegis_dump_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk200        (clk200),
        .rstn          (rstn),
        .collect_i     (collect_i),
        .wr_count_i    (wr_count_i),
        .mem_rd_en_o   (mem_rd_en_o),
        .mem_rd_addr_o (mem_rd_addr_o),
        .mem_rd_data_i (mem_rd_data_i),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_data_o      (m_data_o),
        .m_last_o      (m_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk200 = ~clk200;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk200) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    word_t         exp_q[$];
    int            trig_cyc = -1, done_at = -1, exp_n = 0, rd_next = 0;
    int            n_issued = 0, n_xfer = 0, done_seen = 0, first_valid = -1;
    int            done_cyc = -1, start_cyc = 0, max_addr = -1, ready_mode = 0;
    bit            nz = 1'b0, busy_model = 1'b0;
    logic          prev_stall = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0, first_word = '0;
    bit            pend_v = 1'b0;
    int            pend_a = 0;

    function automatic logic [DW-1:0] pat(input int a);
        logic [DW-1:0] v;
        v = DW'(a);
        return 32'hC0DE_0000 + (v * 32'd7);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Memory model: data for the address issued in cycle k is presented during cycle k+1.
    always @(negedge clk200) begin
        mem_rd_data_i = pend_v ? pat(pend_a) : 32'hDEAD_BEEF;
        pend_v = mem_rd_en_o;
        pend_a = int'(mem_rd_addr_o);
    end

    // Reference model and compare process.
    always @(negedge clk200) begin
        word_t w;
        if (!rstn) begin
            chk("rst_valid", m_valid_o, 0);
            chk("rst_data", m_data_o, 0);
            chk("rst_last", m_last_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_rd_en", mem_rd_en_o, 0);
            chk("rst_rd_addr", mem_rd_addr_o, 0);
            exp_q.delete();
            busy_model = 1'b0;
            done_at = -1;
            trig_cyc = -1;
            prev_stall = 1'b0;
            rd_next = 0;
            n_issued = 0;
            n_xfer = 0;
        end else begin
            if (cyc == trig_cyc && !nz) done_at = cyc + 1;
            if (cyc == trig_cyc + 1 && nz) busy_model = 1'b1;
            if (cyc == done_at) busy_model = 1'b0;
            chk("busy", busy_o, busy_model);
            chk("done", done_o, cyc == done_at);
            if (done_o) begin
                done_seen++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                chk("stall_valid", m_valid_o, 1);
                chk("stall_data", m_data_o, prev_data);
                chk("stall_last", m_last_o, prev_last);
            end
            if (mem_rd_en_o) begin
                n_issued++;
                chk("rd_addr", mem_rd_addr_o, rd_next);
                chk("rd_in_range", rd_next < exp_n, 1);
                if (int'(mem_rd_addr_o) > max_addr) max_addr = int'(mem_rd_addr_o);
                rd_next++;
            end
            if (m_valid_o && m_ready_i) begin
                n_xfer++;
                if (first_valid < 0) begin
                    first_valid = cyc;
                    first_word = m_data_o;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word actual=%0h required=none cycle=%0d", m_data_o, cyc);
                end else begin
                    w = exp_q.pop_front();
                    chk("word_data", m_data_o, w.d);
                    chk("word_last", m_last_o, w.l);
                    if (w.l) done_at = cyc + 1;
                end
            end
            chk("outstanding", (n_issued - n_xfer) <= 2, 1);
            prev_stall = m_valid_o && !m_ready_i;
            prev_data = m_data_o;
            prev_last = m_last_o;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk200);
            #1;
        end
    endtask

    task automatic start_dump(input int count);
        int sat;
        sat = (count > (1 << AW)) ? (1 << AW) : count;
        wr_count_i = (AW+1)'(count);
        collect_i = 1'b0;
        exp_n = sat;
        rd_next = 0;
        n_issued = 0;
        n_xfer = 0;
        first_valid = -1;
        done_cyc = -1;
        max_addr = -1;
        nz = (sat > 0) || (HDR != 0);
        if (HDR != 0) exp_q.push_back('{d: DW'(sat), l: (sat == 0)});
        for (int i = 0; i < sat; i++) exp_q.push_back('{d: pat(i), l: (i == sat - 1)});
        start_cyc = cyc;
        trig_cyc = cyc + 2;
    endtask

    task automatic wait_done(input int budget, input string name);
        int start;
        int k;
        start = done_seen;
        k = 0;
        while (done_seen == start && k < budget) begin
            @(posedge clk200);
            #1;
            if (ready_mode != 0) m_ready_i = ((cyc / 3) % 2) == 0;
            k++;
        end
        checks++;
        if (done_seen == start) begin
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done_within_%0d", name, budget);
        end
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int c;
        int ds;
        int k;

        rstn = 1'b0;
        step(3);
        rstn = 1'b1;
        step(2);

        // Count 8, always ready
        collect_i = 1'b1;
        step(4);
        start_dump(8);
        c = start_cyc;
        wait_done(60, "c8");
        chk("c8_first_valid", first_valid - c, 5);
        chk("c8_done_cycle", done_cyc - c, 13 + HDR);
        chk("c8_words", n_xfer, 8 + HDR);
        chk("c8_reads", n_issued, 8);

        // Count 0
        step(2);
        collect_i = 1'b1;
        step(4);
        start_dump(0);
        c = start_cyc;
        wait_done(30, "c0");
        chk("c0_done_cycle", done_cyc - c, (HDR != 0) ? 6 : 3);
        chk("c0_reads", n_issued, 0);
        chk("c0_words", n_xfer, HDR);

        // Count 16, ready toggling every 3 cycles
        step(2);
        collect_i = 1'b1;
        step(4);
        start_dump(16);
        ready_mode = 1;
        wait_done(300, "c16");
        ready_mode = 0;
        m_ready_i = 1'b1;
        chk("c16_words", n_xfer, 16 + HDR);
        chk("c16_reads", n_issued, 16);

        // Count 2000 saturates to full depth
        step(2);
        collect_i = 1'b1;
        step(4);
        start_dump(2000);
        wait_done(1500, "c2000");
        chk("c2000_words", n_xfer, 1024 + HDR);
        chk("c2000_max_addr", max_addr, 1023);

        // Count 32 aborted by reset, then a clean count 4
        step(2);
        collect_i = 1'b1;
        step(4);
        start_dump(32);
        k = 0;
        while (n_xfer < 10 + HDR && k < 200) begin
            step(1);
            k++;
        end
        chk("c32_progress", n_xfer >= 10 + HDR, 1);
        ds = done_seen;
        rstn = 1'b0;
        step(3);
        chk("c32_no_done", done_seen, ds);
        rstn = 1'b1;
        step(2);
        collect_i = 1'b1;
        step(4);
        start_dump(4);
        wait_done(60, "c4");
        chk("c4_words", n_xfer, 4 + HDR);
        chk("c4_reads", n_issued, 4);

        // Count 64 with a Collect re-pulse mid-dump, then a new dump
        step(2);
        collect_i = 1'b1;
        step(4);
        start_dump(64);
        step(10);
        collect_i = 1'b1;
        step(5);
        collect_i = 1'b0;
        wait_done(300, "c64");
        chk("c64_words", n_xfer, 64 + HDR);
`ifdef DUMP_HEADER_EN
        chk("c64_header", first_word, 64);
`else
        chk("c64_first_word", first_word, 32'hC0DE_0000);
`endif
        step(2);
        collect_i = 1'b1;
        step(4);
        start_dump(5);
        wait_done(60, "c5");
        chk("c5_words", n_xfer, 5 + HDR);

        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
